// File: rtl/count_monitor.sv
// Watches a free-running 4-bit counter: buffers each change, flags
// 15->0 rollovers and raises a stall flag when the value stops moving.
module count_monitor #(
    parameter int STALL_LIMIT = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] counter,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       wrap_pulse,
    output logic [7:0] wrap_count,
    output logic       stall,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        STALLED
    } state_t;

    state_t        state;
    logic [3:0]    prev;
    logic [3:0]    same_cnt;
    logic [3:0]    same_inc;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] remain;
    logic [3:0]    head_next;

    logic active;
    logic change;
    logic wrap;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        active   = (state != IDLE);
        change   = active && (counter != prev);
        wrap     = active && (prev == 4'hF) && (counter == 4'h0);
        full     = (count == CW'(FIFO_DEPTH));
        pop      = out_valid && out_ready;
        push     = change && (!full || pop);
        drop     = change && full && !pop;
        remain   = count - CW'(pop);
        rd_next  = rd_ptr + AW'(pop);
        same_inc = same_cnt + 4'd1;
        // Head after this edge: the next stored entry, or the value being
        // pushed when the buffer would otherwise be empty.
        if (remain == '0) begin
            head_next = push ? counter : out_data;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= 4'd0;
            same_cnt   <= 4'd0;
            stall      <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= 8'd0;
        end else begin
            wrap_pulse <= wrap;
            if (wrap) begin
                wrap_count <= wrap_count + 8'd1;
            end
            unique case (state)
                IDLE: begin
                    prev     <= counter;
                    same_cnt <= 4'd0;
                    state    <= TRACK;
                end
                TRACK: begin
                    if (change) begin
                        prev     <= counter;
                        same_cnt <= 4'd0;
                    end else begin
                        same_cnt <= same_inc;
                        if (same_inc == 4'(STALL_LIMIT)) begin
                            state <= STALLED;
                            stall <= 1'b1;
                        end
                    end
                end
                STALLED: begin
                    if (change) begin
                        prev     <= counter;
                        same_cnt <= 4'd0;
                        state    <= TRACK;
                        stall    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_next;
            count     <= remain + CW'(push);
            out_valid <= (remain + CW'(push)) != '0;
            out_data  <= head_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= counter;
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed vector bench for count_monitor with default parameters.
module tb_count_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] counter;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       stall;
    logic       overflow;

    int applied;
    int miscompares;

    typedef struct {
        logic       r;
        logic [3:0] c;
        logic       rdy;
        logic       v;
        logic [3:0] d;
        logic       wp;
        logic [7:0] wc;
        logic       st;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    count_monitor #(
        .STALL_LIMIT(4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .counter   (counter),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count),
        .stall     (stall),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [3:0] c,
                                input logic rdy, input logic v,
                                input logic [3:0] d, input logic wp,
                                input logic [7:0] wc, input logic st,
                                input logic ov);
        vec_t e;
        e.r = r; e.c = c; e.rdy = rdy;
        e.v = v; e.d = d; e.wp = wp;
        e.wc = wc; e.st = st; e.ov = ov;
        tbl.push_back(e);
    endfunction

    task automatic step(input logic r, input logic [3:0] c, input logic rdy);
        reset     = r;
        counter   = c;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // out_data is only meaningful while valid, or right after reset.
    task automatic check(input string tag, input logic r, input logic v,
                         input logic [3:0] d, input logic wp,
                         input logic [7:0] wc, input logic st,
                         input logic ov);
        logic bad;
        applied++;
        bad = (out_valid !== v) || (wrap_pulse !== wp) ||
              (wrap_count !== wc) || (stall !== st) ||
              (overflow !== ov) || ((v || r) && (out_data !== d));
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got v=%0b d=%0d wp=%0b wc=%0d st=%0b ov=%0b want v=%0b d=%0d wp=%0b wc=%0d st=%0b ov=%0b",
                     tag, out_valid, out_data, wrap_pulse, wrap_count,
                     stall, overflow, v, d, wp, wc, st, ov);
        end
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        reset       = 1'b1;
        counter     = 4'd0;
        out_ready   = 1'b0;

        // free-running count with a single rollover
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            add(0, 4'(i), 1, 1, 4'(i), 0, 0, 0, 0);
        end
        add(0, 0, 1, 1, 0, 1, 1, 0, 0);
        // held at 9: stall after the 4th unchanged sample
        add(0, 9, 1, 1, 9, 0, 1, 0, 0);
        add(0, 9, 1, 0, 9, 0, 1, 0, 0);
        add(0, 9, 1, 0, 9, 0, 1, 0, 0);
        add(0, 9, 1, 0, 9, 0, 1, 0, 0);
        add(0, 9, 1, 0, 9, 0, 1, 1, 0);
        add(0, 9, 1, 0, 9, 0, 1, 1, 0);
        add(0, 10, 1, 1, 10, 0, 1, 0, 0);
        add(0, 10, 1, 0, 10, 0, 1, 0, 0);
        // consumer stalled: fifth change dropped
        add(0, 1, 0, 1, 1, 0, 1, 0, 0);
        add(0, 2, 0, 1, 1, 0, 1, 0, 0);
        add(0, 3, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4, 0, 1, 1, 0, 1, 0, 0);
        add(0, 5, 0, 1, 1, 0, 1, 0, 1);
        add(0, 5, 1, 1, 2, 0, 1, 0, 1);
        add(0, 5, 1, 1, 3, 0, 1, 0, 1);
        add(0, 5, 1, 1, 4, 0, 1, 0, 1);
        add(0, 5, 1, 0, 4, 0, 1, 1, 1);
        // reset clears sticky overflow and stall; first sample not pushed
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 4, 0, 1, 4, 0, 0, 0, 0);
        add(0, 5, 0, 1, 4, 0, 0, 0, 0);
        add(0, 6, 0, 1, 4, 0, 0, 0, 0);
        add(0, 7, 0, 1, 4, 0, 0, 0, 0);
        // full buffer: push and pop on the same edge
        add(0, 8, 1, 1, 5, 0, 0, 0, 0);
        add(0, 8, 1, 1, 6, 0, 0, 0, 0);
        add(0, 8, 1, 1, 7, 0, 0, 0, 0);
        add(0, 8, 1, 1, 8, 0, 0, 0, 0);
        add(0, 8, 1, 0, 8, 0, 0, 1, 0);
        // upstream reset 7->0 is a plain change
        add(0, 7, 1, 1, 7, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // three rollovers, then fill and stall
        add(0, 15, 1, 1, 15, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 1, 0, 0);
        add(0, 15, 1, 1, 15, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 1, 2, 0, 0);
        add(0, 15, 1, 1, 15, 0, 2, 0, 0);
        add(0, 0, 1, 1, 0, 1, 3, 0, 0);
        add(0, 1, 0, 1, 0, 0, 3, 0, 0);
        add(0, 2, 0, 1, 0, 0, 3, 0, 0);
        add(0, 3, 0, 1, 0, 0, 3, 0, 0);
        add(0, 3, 0, 1, 0, 0, 3, 0, 0);
        add(0, 3, 0, 1, 0, 0, 3, 0, 0);
        add(0, 3, 0, 1, 0, 0, 3, 0, 0);
        add(0, 3, 0, 1, 0, 0, 3, 1, 0);
        // reset mid-stall with full buffer and wrap_count=3
        add(1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3, 1, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].c, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].r, tbl[i].v, tbl[i].d,
                  tbl[i].wp, tbl[i].wc, tbl[i].st, tbl[i].ov);
        end

        // head held while the consumer stalls, then push+pop not full
        step(0, 4, 0);
        check("hold_push", 0, 1, 4, 0, 0, 0, 0);
        step(0, 5, 0);
        check("hold_two", 0, 1, 4, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 5, 0);
            check($sformatf("hold_stable%0d", k), 0, 1, 4, 0, 0, 0, 0);
        end
        step(0, 6, 1);
        check("pushpop_mid", 0, 1, 5, 0, 0, 0, 0);
        step(0, 6, 1);
        check("drain_6", 0, 1, 6, 0, 0, 0, 0);
        step(0, 6, 1);
        check("drain_empty", 0, 0, 6, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
